// File: rtl/alu_seq_if.sv
// Command and response handshakes between a requester and alu_sequencer.
// master drives commands and consumes responses; slave is the sequencer.
interface alu_seq_if #(
  parameter int DW = 4,
  parameter int AW = 2
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_srca;
  logic [AW-1:0] cmd_srcb;
  logic          cmd_use_imm;
  logic [DW-1:0] cmd_imm;
  logic [AW-1:0] cmd_dst;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_dst;
  logic          rsp_zero;

  modport master (
    output cmd_valid, cmd_op, cmd_srca, cmd_srcb,
    output cmd_use_imm, cmd_imm, cmd_dst, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_dst, rsp_zero
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_srca, cmd_srcb,
    input  cmd_use_imm, cmd_imm, cmd_dst, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_dst, rsp_zero
  );
endinterface

// File: rtl/alu_sequencer.sv
// Register-transfer sequencer in front of a 4-bit combinational ALU.
// IDLE accepts a command, EXEC writes back the ALU result, RESP returns it.
module alu_sequencer #(
  parameter int DW = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  alu_seq_if.slave      bus,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_op,
  input  logic [DW-1:0] alu_result
);
  localparam int NR = 1 << AW;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t        state;
  logic [DW-1:0] rf [NR];
  logic [AW-1:0] dst;

  assign bus.cmd_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      dst           <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_op        <= 3'b000;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_dst   <= '0;
      bus.rsp_zero  <= 1'b0;
      for (int i = 0; i < NR; i++) rf[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            alu_a  <= rf[bus.cmd_srca];
            alu_b  <= bus.cmd_use_imm ? bus.cmd_imm
                                      : rf[bus.cmd_srcb];
            alu_op <= bus.cmd_op;
            dst    <= bus.cmd_dst;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rf[dst]       <= alu_result;
          bus.rsp_data  <= alu_result;
          bus.rsp_dst   <= dst;
          bus.rsp_zero  <= (alu_result == '0);
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Table-driven scoreboard bench for alu_sequencer with a behavioural ALU.
// Expected results are queued at drive time and popped on each handshake.
module tb_alu_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_result;

  alu_seq_if #(.DW(4), .AW(2)) bus ();

  alu_sequencer #(.DW(4), .AW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result = 4'd0;
    case (alu_op)
      3'b001: alu_result = alu_a + alu_b;
      3'b010: alu_result = alu_a - alu_b;
      3'b011: alu_result = alu_a & alu_b;
      3'b100: alu_result = alu_a | alu_b;
      3'b101: alu_result = ~alu_a;
      3'b110: alu_result = ~alu_b;
      default: alu_result = 4'd0;
    endcase
  end

  typedef struct {
    logic [2:0] op;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic       use_imm;
    logic [3:0] imm;
    logic [1:0] dst;
    logic [3:0] exp;
  } vec_t;

  typedef struct {
    logic [3:0] data;
    logic [1:0] dst;
    logic       zero;
  } rsp_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   n_hs = 0;
  rsp_t q[$];
  vec_t tv[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [2:0] op, logic [1:0] sa,
                              logic [1:0] sb, logic ui, logic [3:0] im,
                              logic [1:0] d, logic [3:0] e);
    vec_t v;
    v.op = op; v.srca = sa; v.srcb = sb;
    v.use_imm = ui; v.imm = im; v.dst = d; v.exp = e;
    return v;
  endfunction

  function automatic rsp_t exp_of(vec_t v);
    rsp_t r;
    r.data = v.exp;
    r.dst  = v.dst;
    r.zero = (v.exp == 4'd0);
    return r;
  endfunction

  // Response monitor: a handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      n_hs++;
      if (q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = q.pop_front();
        chk("rsp_data", bus.rsp_data, e.data);
        chk("rsp_dst", bus.rsp_dst, e.dst);
        chk("rsp_zero", bus.rsp_zero, e.zero);
      end
    end
  end

  task automatic drive(vec_t v);
    bus.cmd_op      = v.op;
    bus.cmd_srca    = v.srca;
    bus.cmd_srcb    = v.srcb;
    bus.cmd_use_imm = v.use_imm;
    bus.cmd_imm     = v.imm;
    bus.cmd_dst     = v.dst;
  endtask

  task automatic wait_drain(string name);
    bit done = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (q.size() == 0) begin
        done = 1;
        break;
      end
    end
    chk(name, done, 1);
  endtask

  // Called at posedge+1 in IDLE; returns at posedge+1 after the handshake.
  task automatic send(vec_t v);
    bit rdy = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.cmd_ready) begin
        rdy = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("cmd_ready_wait", rdy, 1);
    drive(v);
    bus.cmd_valid = 1'b1;
    q.push_back(exp_of(v));
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("alu_op_latched", alu_op, v.op);
    chk("rsp_valid_n", bus.rsp_valid, 0);
    @(posedge clk); #1;
    chk("rsp_valid_n1", bus.rsp_valid, 1);
    wait_drain("rsp_timeout");
  endtask

  initial begin
    vec_t a;
    vec_t b;
    logic [3:0] snap_d;
    logic [1:0] snap_t;
    int hs0;

    for (int r = 0; r < 4; r++)
      tv.push_back(mk(3'b001, 2'(r), 2'd0, 1, 4'd0, 2'(r), 4'd0));
    tv.push_back(mk(3'b001, 0, 0, 1, 4'd5, 0, 4'd5));
    tv.push_back(mk(3'b001, 0, 0, 1, 4'd4, 1, 4'd9));
    tv.push_back(mk(3'b001, 0, 1, 0, 4'd0, 2, 4'd14));
    tv.push_back(mk(3'b001, 0, 0, 1, 4'd4, 0, 4'd9));
    tv.push_back(mk(3'b001, 0, 0, 1, 4'd7, 0, 4'd0));
    tv.push_back(mk(3'b010, 0, 0, 1, 4'd1, 0, 4'd15));
    tv.push_back(mk(3'b010, 0, 0, 1, 4'd3, 0, 4'd12));
    tv.push_back(mk(3'b001, 1, 0, 1, 4'd1, 1, 4'd10));
    tv.push_back(mk(3'b000, 0, 1, 0, 4'd0, 2, 4'd0));
    tv.push_back(mk(3'b001, 0, 1, 0, 4'd0, 2, 4'd6));
    tv.push_back(mk(3'b010, 0, 1, 0, 4'd0, 2, 4'd2));
    tv.push_back(mk(3'b011, 0, 1, 0, 4'd0, 2, 4'd8));
    tv.push_back(mk(3'b100, 0, 1, 0, 4'd0, 2, 4'd14));
    tv.push_back(mk(3'b101, 0, 1, 0, 4'd0, 2, 4'd3));
    tv.push_back(mk(3'b110, 0, 1, 0, 4'd0, 2, 4'd5));
    tv.push_back(mk(3'b111, 0, 1, 0, 4'd0, 2, 4'd0));
    tv.push_back(mk(3'b001, 3, 0, 1, 4'd7, 3, 4'd7));
    tv.push_back(mk(3'b001, 3, 3, 0, 4'd0, 3, 4'd14));
    tv.push_back(mk(3'b001, 3, 0, 1, 4'd0, 3, 4'd14));

    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("cmd_ready_after_rst", bus.cmd_ready, 1);

    // Load r1, then reset while a second command is in EXEC.
    @(posedge clk); #1;
    send(mk(3'b001, 0, 0, 1, 4'd6, 1, 4'd6));
    drive(mk(3'b001, 0, 0, 1, 4'd9, 2, 4'd9));
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("exec_cmd_ready", bus.cmd_ready, 0);
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_alu_op", alu_op, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_cmd_ready", bus.cmd_ready, 1);
    @(posedge clk); #1;
    chk("midrst_no_rsp", bus.rsp_valid, 0);

    foreach (tv[i]) send(tv[i]);

    // Backpressure: hold the response while the next command waits.
    a = mk(3'b001, 0, 0, 1, 4'd1, 2, 4'd13);
    b = mk(3'b001, 2, 0, 1, 4'd1, 2, 4'd14);
    hs0 = n_hs;
    bus.rsp_ready = 1'b0;
    drive(a);
    bus.cmd_valid = 1'b1;
    q.push_back(exp_of(a));
    q.push_back(exp_of(b));
    @(posedge clk); #1;
    drive(b);
    @(posedge clk); #1;
    chk("bp_rsp_valid", bus.rsp_valid, 1);
    snap_d = bus.rsp_data;
    snap_t = bus.rsp_dst;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_cmd_ready", bus.cmd_ready, 0);
      chk("bp_valid_held", bus.rsp_valid, 1);
      chk("bp_data_held", bus.rsp_data, snap_d);
      chk("bp_dst_held", bus.rsp_dst, snap_t);
      @(posedge clk); #1;
    end
    chk("bp_no_hs", n_hs, hs0);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_ready", bus.cmd_ready, 1);
    chk("bp_released", bus.rsp_valid, 0);
    chk("bp_one_hs", n_hs, hs0 + 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("bp_second_accept", bus.cmd_ready, 0);
    wait_drain("bp_timeout");
    chk("bp_total_hs", n_hs, hs0 + 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
